// File: rtl/alu_div_pkg.sv
// Shared definitions for the per-thread iterative divider.
//   div_state_t          : FSM encoding (idle / iterating / result held)
//   DIV_WIDTH            : default operand width
//   DIV_BY_ZERO_QUOTIENT : quotient reported when the divisor is zero
//   DIV_CNT_W            : iteration counter width for the default width
//   div_cnt_width()      : counter width for an arbitrary operand width
package alu_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 8;
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOTIENT = '1;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // The counter only has to reach w-1; keep at least one bit for w == 1.
  function automatic int div_cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   rem_in  : current partial remainder (always < div_in)
//   quo_in  : current quotient register (low bits hold quotient so far,
//             high bits still hold unconsumed dividend bits)
//   div_in  : latched divisor (non-zero)
//   rem_out : partial remainder after the step
//   quo_out : quotient register after the step
module alu_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] div_in,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // Upper half of {rem, quo} << 1; needs WIDTH+1 bits because rem may
  // already use its top bit before the shift.
  logic [WIDTH:0]   upper;
  // One extra bit beyond upper acts as the borrow / sign of the trial.
  logic [WIDTH+1:0] diff;

  always_comb begin
    upper = {rem_in, quo_in[WIDTH-1]};
    diff  = {1'b0, upper} - {2'b00, div_in};
    if (!diff[WIDTH+1]) begin
      // Trial fits: difference is < divisor, so it fits in WIDTH bits.
      rem_out = WIDTH'(diff);
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      // Restore: upper < divisor here, so it also fits in WIDTH bits.
      rem_out = WIDTH'(upper);
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider serving one thread's ALU.
// A request is accepted in IDLE, WIDTH restoring steps run in CALC (one per
// enabled clock), and the result is held in DONE until the ALU takes it.
// Divide-by-zero skips CALC and reports all-ones / dividend / flag.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   enable              : thread active; low freezes the block
//   req_valid/req_ready : request handshake (dividend, divisor sampled)
//   resp_valid/resp_ready: response handshake (quotient, remainder,
//                         div_by_zero held stable while resp_valid)
//   busy                : state is not IDLE
module alu_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] quo_reg,   quo_next;
  logic [WIDTH-1:0] rem_reg,   rem_next;
  logic [WIDTH-1:0] div_reg,   div_next;
  logic             dbz_reg,   dbz_next;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  alu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .div_in  (div_reg),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= DIV_IDLE;
      count_reg <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      div_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      div_reg   <= div_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    div_next   = div_reg;
    dbz_next   = dbz_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;

    unique case (state_reg)
      DIV_IDLE: begin
        req_ready = enable;
        if (enable && req_valid) begin
          div_next = divisor;
          if (divisor != '0) begin
            state_next = DIV_CALC;
            count_next = '0;
            rem_next   = '0;
            // The dividend is shifted out of the quotient register one bit
            // per step while quotient bits are shifted in at the bottom.
            quo_next   = dividend;
            dbz_next   = 1'b0;
          end else begin
            state_next = DIV_DONE;
            quo_next   = {WIDTH{1'b1}};
            rem_next   = dividend;
            dbz_next   = 1'b1;
          end
        end
      end

      DIV_CALC: begin
        if (enable) begin
          rem_next   = step_rem;
          quo_next   = step_quo;
          count_next = count_reg + CNT_W'(1);
          if (count_reg == CNT_W'(WIDTH - 1)) begin
            state_next = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        resp_valid = 1'b1;
        if (enable && resp_ready) begin
          state_next = DIV_IDLE;
        end
      end

      default: begin
        state_next = DIV_IDLE;
      end
    endcase
  end

  assign quotient    = quo_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;
  assign busy        = (state_reg != DIV_IDLE);

endmodule

// File: tb/tb_alu_divider.sv
// Bench for alu_divider: expected results are pushed when a request is
// accepted and popped when the matching response is observed.
module tb_alu_divider;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b1;
  logic         req_valid = 1'b0;
  logic         resp_ready = 1'b1;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  alu_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample/drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (the accept edge), then scramble the
  // operand inputs and record the expected result.
  task automatic send(input logic [W-1:0] n, input logic [W-1:0] d);
    exp_t e;
    dividend  = n;
    divisor   = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    dividend  = W'($urandom);
    divisor   = W'($urandom);
    e.n   = n;
    e.d   = d;
    e.dbz = (d == 0);
    e.q   = (d == 0) ? 8'hFF : n / d;
    e.r   = (d == 0) ? n : n % d;
    sb.push_back(e);
  endtask

  // Edges counted after the accept edge until resp_valid is seen; -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    if (resp_valid !== 1'b1) lat = -1;
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: got empty queue want an entry");
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if ({busy, resp_valid, quotient, remainder, div_by_zero, req_ready} !==
        {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got busy=%b rv=%b q=%0d r=%0d dbz=%b rr=%b want 0 0 0 0 0 1",
               busy, resp_valid, quotient, remainder, div_by_zero, req_ready);
    end
    reset = 1'b1;
    tick();
    $display("reset: busy=%b q=%0d r=%0d", busy, quotient, remainder);
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_ready: got %b want 1", req_ready);
    end
    send(8'd200, 8'd7);
    wait_resp(lat);
    pop_exp(e);
    total++;
    if (lat != W) begin
      bad++;
      $display("FAIL basic_latency: got %0d want %0d", lat, W);
    end
    total++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      bad++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    tick();
    total++;
    if ({busy, resp_valid, req_ready} !== 3'b001) begin
      bad++;
      $display("FAIL basic_idle: got busy=%b rv=%b rr=%b want 0 0 1", busy, resp_valid, req_ready);
    end
    $display("200/7: lat=%0d q=%0d r=%0d", lat, e.q, e.r);
  endtask

  task automatic test_div_zero();
    exp_t e;
    int   lat;
    send(8'd5, 8'd0);
    wait_resp(lat);
    pop_exp(e);
    total++;
    if (lat != 0) begin
      bad++;
      $display("FAIL dbz_latency: got %0d want 0", lat);
    end
    total++;
    if ({quotient, remainder, div_by_zero} !== {8'hFF, 8'd5, 1'b1} ||
        {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      bad++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b want q=255 r=5 dbz=1",
               quotient, remainder, div_by_zero);
    end
    tick();
    $display("5/0: lat=%0d q=%0d r=%0d dbz=%b", lat, e.q, e.r, e.dbz);
    send(8'd9, 8'd3);
    wait_resp(lat);
    pop_exp(e);
    total++;
    if ({quotient, remainder, div_by_zero} !== {8'd3, 8'd0, 1'b0} || lat != W) begin
      bad++;
      $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b lat=%0d want q=3 r=0 dbz=0 lat=%0d",
               quotient, remainder, div_by_zero, lat, W);
    end
    tick();
    $display("9/3: lat=%0d q=%0d r=%0d dbz=%b", lat, e.q, e.r, e.dbz);
  endtask

  task automatic test_corners();
    logic [W-1:0] ns [3] = '{8'd255, 8'd7,   8'd255};
    logic [W-1:0] ds [3] = '{8'd1,   8'd200, 8'd255};
    logic [W-1:0] qs [3] = '{8'd255, 8'd0,   8'd1};
    logic [W-1:0] rs [3] = '{8'd0,   8'd7,   8'd0};
    exp_t e;
    int   lat;
    for (int i = 0; i < 3; i++) begin
      send(ns[i], ds[i]);
      wait_resp(lat);
      pop_exp(e);
      total++;
      if ({quotient, remainder, div_by_zero} !== {qs[i], rs[i], 1'b0}) begin
        bad++;
        $display("FAIL corner_%0d: got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=0",
                 i, quotient, remainder, div_by_zero, lat, qs[i], rs[i]);
      end
      $display("%0d/%0d: q=%0d r=%0d", e.n, e.d, quotient, remainder);
      tick();
    end
  endtask

  task automatic test_random();
    exp_t         e;
    int           lat;
    logic [W-1:0] n, d;
    int           errs = 0;
    for (int i = 0; i < 1000; i++) begin
      n = W'($urandom);
      d = ($urandom_range(0, 31) == 0) ? 8'd0 : W'($urandom);
      send(n, d);
      wait_resp(lat);
      pop_exp(e);
      total++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        bad++;
        errs++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                 i, n, d, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
      if (d != 0) begin
        total++;
        if ((32'(quotient) * 32'(d) + 32'(remainder)) != 32'(n) || remainder >= d) begin
          bad++;
          errs++;
          $display("FAIL random_identity_%0d: %0d/%0d got q=%0d r=%0d want q*d+r=n and r<d",
                   i, n, d, quotient, remainder);
        end
      end
      tick();
    end
    $display("random: 1000 pairs, %0d errors", errs);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    resp_ready = 1'b0;
    send(8'd100, 8'd9);
    wait_resp(lat);
    pop_exp(e);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({quotient, remainder, req_ready, resp_valid} !== {e.q, e.r, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL hold_%0d: got q=%0d r=%0d rr=%b rv=%b want q=%0d r=%0d rr=0 rv=1",
                 i, quotient, remainder, req_ready, resp_valid, e.q, e.r);
      end
      if (i == 1) begin
        dividend  = 8'd50;
        divisor   = 8'd5;
        req_valid = 1'b1;
      end
      tick();
      req_valid = 1'b0;
    end
    total++;
    if ({quotient, remainder, resp_valid} !== {8'd11, 8'd1, 1'b1}) begin
      bad++;
      $display("FAIL hold_after_pulse: got q=%0d r=%0d rv=%b want q=11 r=1 rv=1",
               quotient, remainder, resp_valid);
    end
    resp_ready = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, resp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL hold_release: got busy=%b rv=%b want 0 0", busy, resp_valid);
    end
    $display("100/9 backpressure: q=%0d r=%0d", e.q, e.r);
  endtask

  task automatic test_enable_stall();
    exp_t e;
    int   lat;
    send(8'd200, 8'd7);
    tick();
    tick();
    tick();
    enable = 1'b0;
    // After three steps of 200/7: partial remainder 6, register 8'h40.
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({quotient, remainder, busy, resp_valid, req_ready} !==
          {8'h40, 8'd6, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stall_%0d: got q=%h r=%0d busy=%b rv=%b rr=%b want q=40 r=6 busy=1 rv=0 rr=0",
                 i, quotient, remainder, busy, resp_valid, req_ready);
      end
    end
    enable = 1'b1;
    wait_resp(lat);
    if (lat >= 0) lat = lat + 5;
    pop_exp(e);
    total++;
    if (lat != W + 2 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      bad++;
      $display("FAIL stall_result: got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
               lat, quotient, remainder, W + 2, e.q, e.r);
    end
    tick();
    $display("200/7 stalled: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   lat;
    send(8'd200, 8'd7);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    pop_exp(e);
    total++;
    if ({busy, resp_valid, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, 8'd0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b rv=%b q=%0d r=%0d dbz=%b want 0 0 0 0 0",
               busy, resp_valid, quotient, remainder, div_by_zero);
    end
    send(8'd9, 8'd3);
    wait_resp(lat);
    pop_exp(e);
    total++;
    if (lat != W || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      bad++;
      $display("FAIL after_reset: got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
               lat, quotient, remainder, W, e.q, e.r);
    end
    tick();
    $display("mid-CALC reset then 9/3: q=%0d r=%0d", quotient, remainder);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_corners();
    test_backpressure();
    test_enable_stall();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
